// File: rtl/playback_pkg.sv
// Shared definitions for the sample playback controller: state encoding and
// default sample width / midscale idle code.
package playback_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int CNT_W_DEF    = 24;
  localparam logic [15:0] IDLE_CODE_DEF = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/sample_playback_ctrl.sv
// Streams {ch1, ch2} sample pairs from a standard (non-FWFT) FIFO to a DAC,
// either for a fixed word count or continuously until stopped.
module sample_playback_ctrl
  import playback_pkg::*;
#(
  parameter int                    SAMPLE_W  = SAMPLE_W_DEF,
  parameter int                    CNT_W     = CNT_W_DEF,
  parameter logic [SAMPLE_W-1:0]   IDLE_CODE = IDLE_CODE_DEF
) (
  input  logic                  adc_data_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_W-1:0]      num_words,
  input  logic [2*SAMPLE_W-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_busy,
  input  logic                  sink_rdy,
  output logic                  fifo_rd_en,
  output logic [SAMPLE_W-1:0]   dac_data_1,
  output logic [SAMPLE_W-1:0]   dac_data_2,
  output logic                  dac_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow,
  output logic [CNT_W-1:0]      words_played
);

  state_e              state_q, state_d;
  logic                rd_d1_q, rd_d1_d;
  logic [SAMPLE_W-1:0] dac_data_1_q, dac_data_1_d;
  logic [SAMPLE_W-1:0] dac_data_2_q, dac_data_2_d;
  logic                dac_valid_q, dac_valid_d;
  logic                done_q, done_d;
  logic                underflow_q, underflow_d;
  logic [CNT_W-1:0]    words_played_q, words_played_d;

  logic                exhausted;
  logic                start_ok;
  logic [CNT_W-1:0]    words_next;

  always_comb begin
    exhausted  = (num_words != '0) && (words_played_q == num_words);
    start_ok   = (state_q == ST_IDLE) && start && !stop && !fifo_busy;
    fifo_rd_en = (state_q == ST_RUN) && !fifo_empty && sink_rdy && !stop &&
                 !reset && !exhausted;
    words_next = words_played_q + {{(CNT_W-1){1'b0}}, fifo_rd_en};

    state_d        = state_q;
    rd_d1_d        = fifo_rd_en;
    dac_data_1_d   = dac_data_1_q;
    dac_data_2_d   = dac_data_2_q;
    dac_valid_d    = 1'b0;
    done_d         = (state_q == ST_FLUSH);
    underflow_d    = underflow_q;
    words_played_d = words_next;

    // Data read last cycle is on fifo_dout now; otherwise idle parks at midscale.
    if (rd_d1_q) begin
      dac_data_1_d = fifo_dout[2*SAMPLE_W-1:SAMPLE_W];
      dac_data_2_d = fifo_dout[SAMPLE_W-1:0];
      dac_valid_d  = 1'b1;
    end else if (state_q == ST_IDLE) begin
      dac_data_1_d = IDLE_CODE;
      dac_data_2_d = IDLE_CODE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d        = ST_RUN;
          words_played_d = '0;
          underflow_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (sink_rdy && fifo_empty && !exhausted && !stop)
          underflow_d = 1'b1;
        // Covers both the final counted read and an abort request.
        if (stop || ((num_words != '0) && (words_next == num_words)))
          state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge adc_data_clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rd_d1_q        <= 1'b0;
      dac_data_1_q   <= IDLE_CODE;
      dac_data_2_q   <= IDLE_CODE;
      dac_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      underflow_q    <= 1'b0;
      words_played_q <= '0;
    end else begin
      state_q        <= state_d;
      rd_d1_q        <= rd_d1_d;
      dac_data_1_q   <= dac_data_1_d;
      dac_data_2_q   <= dac_data_2_d;
      dac_valid_q    <= dac_valid_d;
      done_q         <= done_d;
      underflow_q    <= underflow_d;
      words_played_q <= words_played_d;
    end
  end

  assign dac_data_1   = dac_data_1_q;
  assign dac_data_2   = dac_data_2_q;
  assign dac_valid    = dac_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign underflow    = underflow_q;
  assign words_played = words_played_q;

endmodule

// File: tb/tb_sample_playback_ctrl.sv
// Bench for sample_playback_ctrl: queue-based FIFO, timeline reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_sample_playback_ctrl;

  localparam logic [15:0] IDLE = 16'h8000;

  logic        adc_data_clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [23:0] num_words;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_busy;
  logic        sink_rdy;
  logic        fifo_rd_en;
  logic [15:0] dac_data_1;
  logic [15:0] dac_data_2;
  logic        dac_valid;
  logic        busy;
  logic        done;
  logic        underflow;
  logic [23:0] words_played;

  sample_playback_ctrl dut (
    .adc_data_clk (adc_data_clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .num_words    (num_words),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_busy    (fifo_busy),
    .sink_rdy     (sink_rdy),
    .fifo_rd_en   (fifo_rd_en),
    .dac_data_1   (dac_data_1),
    .dac_data_2   (dac_data_2),
    .dac_valid    (dac_valid),
    .busy         (busy),
    .done         (done),
    .underflow    (underflow),
    .words_played (words_played)
  );

  always #5 adc_data_clk = ~adc_data_clk;

  typedef struct {
    int          when;
    logic [31:0] w;
  } pend_t;

  logic [31:0] fifo_q[$];
  pend_t       pipe[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_rd     = 0;
  int n_done   = 0;
  int cyc      = 0;

  // Reference model: phase 0 idle, 1 playing, 2 draining; outputs expected this cycle.
  int          m_phase;
  logic        m_valid, m_done, m_under;
  logic [15:0] m_d1, m_d2;
  logic [23:0] m_words;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_empty <= 1'b0;
  endtask

  task automatic clear_fifo();
    fifo_q.delete();
    fifo_empty <= 1'b1;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_under = 1'b0;
    m_d1    = IDLE;
    m_d2    = IDLE;
    m_words = '0;
    pipe.delete();
  endtask

  // One clock cycle: inputs already driven; compare, advance model, run FIFO.
  task automatic run_cycle();
    logic        exh, exp_rd, acc, do_pop;
    logic [31:0] w_model, popped;
    logic [23:0] nxt_words;
    pend_t       e;
    #3;
    exh    = (num_words != 0) && (m_words == num_words);
    exp_rd = (m_phase == 1) && (fifo_q.size() != 0) && sink_rdy && !stop && !reset && !exh;
    check_output("rd_en", fifo_rd_en, exp_rd);
    check_output("valid", dac_valid, m_valid);
    check_output("data1", dac_data_1, m_d1);
    check_output("data2", dac_data_2, m_d2);
    check_output("busy", busy, m_phase != 0);
    check_output("done", done, m_done);
    check_output("underflow", underflow, m_under);
    check_output("words", words_played, m_words);
    if (fifo_rd_en) n_rd++;
    if (done) n_done++;

    w_model = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    if (reset) begin
      model_reset();
    end else begin
      acc       = (m_phase == 0) && start && !stop && !fifo_busy;
      nxt_words = acc ? 24'd0 : m_words + (exp_rd ? 24'd1 : 24'd0);
      if (pipe.size() != 0 && pipe[0].when == cyc + 1) begin
        e       = pipe.pop_front();
        m_valid = 1'b1;
        m_d1    = e.w[31:16];
        m_d2    = e.w[15:0];
      end else begin
        m_valid = 1'b0;
        if (m_phase == 0) begin
          m_d1 = IDLE;
          m_d2 = IDLE;
        end
      end
      if (exp_rd) begin
        e.when = cyc + 2;
        e.w    = w_model;
        pipe.push_back(e);
      end
      m_done = (m_phase == 2);
      if (acc) m_under = 1'b0;
      else if (m_phase == 1 && sink_rdy && fifo_q.size() == 0 && !exh && !stop) m_under = 1'b1;
      m_words = nxt_words;
      case (m_phase)
        0:       if (acc) m_phase = 1;
        1:       if (stop || (num_words != 0 && nxt_words == num_words)) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    cyc++;

    do_pop = fifo_rd_en && (fifo_q.size() != 0);
    popped = do_pop ? fifo_q.pop_front() : 32'h0;
    @(posedge adc_data_clk);
    if (do_pop) begin
      fifo_dout  <= popped;
      fifo_empty <= (fifo_q.size() == 0);
    end
    @(negedge adc_data_clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    run_cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      run_cycle();
      if (done) got = 1'b1;
    end
  endtask

  task automatic run_until_reads(input int target, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      run_cycle();
      if (n_rd >= target) got = 1'b1;
    end
  endtask

  task automatic apply_stimulus();
    bit got;
    // Reset values
    check_output("rst_data1", dac_data_1, IDLE);
    check_output("rst_busy", busy, 0);
    check_output("rst_words", words_played, 0);
    reset = 1'b0;
    run_cycle();

    // Fixed count of four preloaded words
    push_word(32'h00010002); push_word(32'h00030004);
    push_word(32'h00050006); push_word(32'h00070008);
    num_words = 24'd4; sink_rdy = 1'b1; n_rd = 0;
    pulse_start();
    run_until_done(20, got);
    check_output("s1_done_seen", got, 1);
    check_output("s1_last_d1", dac_data_1, 16'h0007);
    check_output("s1_last_d2", dac_data_2, 16'h0008);
    check_output("s1_last_valid", dac_valid, 1);
    check_output("s1_reads", n_rd, 4);
    run_cycle();
    check_output("s1_idle_d1", dac_data_1, IDLE);
    check_output("s1_idle_busy", busy, 0);

    // Continuous mode stopped after six reads
    for (int i = 0; i < 10; i++) push_word(32'h01000100 * (i + 1));
    num_words = 24'd0; n_rd = 0;
    pulse_start();
    run_until_reads(6, 40, got);
    check_output("s2_six_reads", got, 1);
    stop = 1'b1;
    run_cycle();
    stop = 1'b0;
    check_output("s2_no_done_early", done, 0);
    run_cycle();
    check_output("s2_done", done, 1);
    check_output("s2_words", words_played, 6);
    check_output("s2_reads", n_rd, 6);
    clear_fifo();
    run_cycle();

    // Underflow with a short FIFO, completed by a late refill
    for (int i = 0; i < 3; i++) push_word(32'h00110022 + i);
    num_words = 24'd8; n_rd = 0;
    pulse_start();
    run_until_reads(3, 20, got);
    check_output("s3_three_reads", got, 1);
    run_cycle();
    run_cycle();
    check_output("s3_underflow", underflow, 1);
    check_output("s3_busy", busy, 1);
    for (int i = 0; i < 5; i++) push_word(32'h00330044 + i);
    run_until_done(40, got);
    check_output("s3_done_seen", got, 1);
    check_output("s3_underflow_held", underflow, 1);
    check_output("s3_words", words_played, 8);
    run_cycle();

    // Alternating sink ready
    for (int i = 0; i < 4; i++) push_word(32'h0A0B0C0D + i);
    num_words = 24'd4; n_rd = 0;
    pulse_start();
    check_output("s4_underflow_cleared", underflow, 0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      sink_rdy = ~sink_rdy;
      run_cycle();
      if (done) got = 1'b1;
    end
    sink_rdy = 1'b1;
    check_output("s4_done_seen", got, 1);
    check_output("s4_reads", n_rd, 4);
    check_output("s4_underflow", underflow, 0);

    // Start rejected by simultaneous stop or FIFO busy
    push_word(32'h12345678);
    start = 1'b1; stop = 1'b1;
    run_cycle();
    start = 1'b0; stop = 1'b0;
    check_output("s5_start_stop_busy", busy, 0);
    fifo_busy = 1'b1;
    pulse_start();
    fifo_busy = 1'b0;
    check_output("s5_fifo_busy_busy", busy, 0);
    clear_fifo();
    run_cycle();

    // Reset mid-run after two of five reads
    for (int i = 0; i < 5; i++) push_word(32'h55556666 + i);
    num_words = 24'd5; n_rd = 0;
    pulse_start();
    run_until_reads(2, 20, got);
    check_output("s6_two_reads", got, 1);
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    check_output("s6_valid", dac_valid, 0);
    check_output("s6_busy", busy, 0);
    check_output("s6_words", words_played, 0);
    check_output("s6_d1", dac_data_1, IDLE);
    check_output("s6_done", done, 0);
    n_done = 0;
    for (int i = 0; i < 4; i++) run_cycle();
    check_output("s6_no_done", n_done, 0);
    clear_fifo();
    run_cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      sink_rdy  = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      fifo_busy = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      if (m_phase == 0 && $urandom_range(0, 3) == 0) num_words = 24'($urandom_range(0, 6));
      if (fifo_q.size() < 12 && $urandom_range(0, 2) == 0) push_word($urandom);
      run_cycle();
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0; fifo_busy = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    num_words  = '0;
    fifo_busy  = 1'b0;
    sink_rdy   = 1'b0;
    fifo_dout  <= '0;
    fifo_empty <= 1'b1;
    model_reset();
    repeat (2) @(negedge adc_data_clk);
    run_cycle();
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_playback_ctrl.md
SAMPLE_PLAYBACK_CTRL -- requirements
Module: sample_playback_ctrl

Interface
REQ-001 Parameter SAMPLE_W, default 16, width of each channel sample.
REQ-002 Parameter CNT_W, default 24, width of word count and played counter.
REQ-003 Parameter IDLE_CODE, default 16'h8000, midscale code driven when not playing.
REQ-004 adc_data_clk  in  1  block clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse that begins playback.
REQ-007 stop  in  1  single-cycle pulse that aborts playback.
REQ-008 num_words  in  CNT_W  number of FIFO words to play; 0 = continuous until stop.
REQ-009 fifo_dout  in  2*SAMPLE_W  FIFO read data, {ch1, ch2}; ch1 in upper half; standard (non-FWFT) FIFO, valid one cycle after fifo_rd_en.
REQ-010 fifo_empty  in  1  FIFO empty flag.
REQ-011 fifo_busy  in  1  FIFO resetting; start is ignored while high.
REQ-012 sink_rdy  in  1  downstream able to accept a sample this cycle.
REQ-013 fifo_rd_en  out  1  FIFO read strobe.
REQ-014 dac_data_1 / dac_data_2  out  SAMPLE_W each  channel 1 / channel 2 samples.
REQ-015 dac_valid  out  1  new sample pair present this cycle.
REQ-016 busy  out  1  high in RUN and FLUSH.
REQ-017 done  out  1  single-cycle completion pulse.
REQ-018 underflow  out  1  sticky underflow flag.
REQ-019 words_played  out  CNT_W  number of FIFO reads issued since last start.

Function
REQ-020 States IDLE, RUN and FLUSH shall be implemented.
REQ-021 IDLE->RUN on start=1 and stop=0 and fifo_busy=0; simultaneous start+stop in IDLE: stay IDLE.
REQ-022 On accepted start: words_played<=0, underflow<=0.
REQ-023 fifo_rd_en = RUN & !fifo_empty & sink_rdy & !stop & !reset & !(num_words!=0 & words_played==num_words) (combinational).
REQ-024 Each fifo_rd_en cycle increments words_played; modulo 2^CNT_W wrap in continuous mode.
REQ-025 RUN->FLUSH at the edge ending the cycle in which the read making words_played==num_words issues (num_words!=0), or on stop=1.
REQ-026 A read delay flag (rd_d1) shall register fifo_rd_en; when rd_d1=1: dac_data_1<=fifo_dout[upper], dac_data_2<=fifo_dout[lower], dac_valid<=1; otherwise dac_valid<=0.
REQ-027 Latency: fifo_rd_en in cycle N -> dac_valid and data visible in cycle N+2.
REQ-028 In RUN, when no read occurs, dac_data_* shall hold their last value.
REQ-029 Underflow: RUN & sink_rdy & fifo_empty & count not exhausted & !stop -> underflow<=1; held until next accepted start or reset; playback continues.
REQ-030 sink_rdy=0 shall suppress reads and shall not set underflow.
REQ-031 FLUSH lasts exactly one cycle (captures pending rd_d1 data), then ->IDLE with done=1 in the following cycle (same cycle as the final dac_valid).
REQ-032 In IDLE, dac_data_1/2 <= IDLE_CODE at each edge not capturing rd_d1 data; dac_valid=0.
REQ-033 start during RUN/FLUSH ignored; stop during IDLE/FLUSH ignored.
REQ-034 num_words changes are sampled continuously; caller shall hold it stable while busy.

Reset
REQ-035 On reset: state=IDLE, fifo_rd_en=0 (same cycle), rd_d1=0, dac_data_1/2=IDLE_CODE, dac_valid=0, busy=0, done=0, underflow=0, words_played=0.
REQ-036 reset mid-RUN aborts without done pulse; the pending FIFO word is discarded.

Structure
REQ-037 Package playback_pkg shall hold the state encoding, SAMPLE_W and IDLE_CODE defaults.
REQ-038 No sub-module; single flat module.

Verification
REQ-039 num_words=4, FIFO preloaded with 4 words 0x00010002..0x00070008, sink_rdy=1, start -> 4 consecutive rd_en, dac_valid 4 cycles from rd_en+2, done with the 4th, then data=0x8000.
REQ-040 num_words=0, 10 words, stop after 6th read -> exactly 6 reads, done 2 cycles after stop, words_played=6.
REQ-041 num_words=8, 3 words preloaded -> underflow=1 after 3rd read; push 5 more -> playback completes, done, underflow remains 1 until next start.
REQ-042 sink_rdy toggling 1/0 each cycle, num_words=4 -> reads only when sink_rdy=1, underflow=0, done after 4 reads.
REQ-043 start+stop same cycle in IDLE -> stays IDLE, busy=0; start with fifo_busy=1 -> ignored.
REQ-044 reset asserted mid-RUN after 2 of 5 reads -> next cycle all outputs at reset values, no done pulse.
